text_glyph_fetch: RTL

//  Pipelined VRAM/font fetch stage between the video timing generator and the text-mode color mapper.
//  Per pixel: reads the 32-bit VRAM word holding the character cell (4 chars/word, 20 words/row,
//  80x30 cells of 8x16 px), selects the byte, fetches the font row, and emits the final

---
 rtl/text_mode_pkg.sv | 52 +++++
 rtl/pipe_delay.sv | 36 +++
 rtl/text_glyph_fetch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/text_mode_pkg.sv
// Shared text-mode geometry and the bundle types carried alongside the glyph fetch pipeline.
package text_mode_pkg;

    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;
    localparam int GLYPH_W        = 8;
    localparam int GLYPH_H        = 16;
    localparam int CHARS_PER_WORD = 4;
    localparam int WORDS_PER_ROW  = 20;
    localparam int VRAM_WORDS     = 600;

    typedef struct packed {
        logic       invert;
        logic [6:0] code;
    } glyph_t;

    // Everything about a pixel that must stay aligned with its VRAM read.
    typedef struct packed {
        logic [9:0] draw_x;
        logic [9:0] draw_y;
        logic       hsync;
        logic       vsync;
        logic       vde;
        logic [1:0] char_sel;
        logic [3:0] row;
        logic [2:0] px_bit;
    } sideband_t;

    // After the byte is selected, only the glyph and output-side fields travel on.
    typedef struct packed {
        glyph_t     glyph;
        logic [9:0] draw_x;
        logic [9:0] draw_y;
        logic       hsync;
        logic       vsync;
        logic       vde;
        logic [2:0] px_bit;
    } stage1_t;

    localparam sideband_t SB_RST = '{draw_x: '0, draw_y: '0, hsync: 1'b1, vsync: 1'b1,
                                     vde: 1'b0, char_sel: '0, row: '0, px_bit: '0};

    localparam stage1_t S1_RST = '{glyph: '0, draw_x: '0, draw_y: '0, hsync: 1'b1,
                                   vsync: 1'b1, vde: 1'b0, px_bit: '0};

    // Word index of a character cell; fits 10 bits for every visible cell (max 599).
    function automatic logic [9:0] cell_word_addr(input logic [5:0] cell_row,
                                                  input logic [4:0] word_col);
        return 10'(cell_row) * 10'(WORDS_PER_ROW) + 10'(word_col);
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register delay line for pipeline sideband; DEPTH=0 is a wire.
module pipe_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RST_VAL;
                    end
                end else begin
                    stage_q[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/text_glyph_fetch.sv
// Pixel-rate VRAM -> font ROM fetch pipeline producing the fg/bg bit for each text-mode pixel.
module text_glyph_fetch
    import text_mode_pkg::*;
#(
    parameter int VRAM_LAT = 1,
    parameter int FONT_LAT = 1,
    parameter int VRAM_AW  = 10
) (
    input  logic               pixel_clk,
    input  logic               reset_n,
    input  logic [9:0]         drawX,
    input  logic [9:0]         drawY,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               vde_in,
    output logic               vram_en,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [31:0]        vram_rdata,
    output logic [10:0]        font_addr,
    input  logic [7:0]         font_data,
    output logic               pix_on,
    output logic [6:0]         glyph_code_o,
    output logic               invert_o,
    output logic [9:0]         drawX_o,
    output logic [9:0]         drawY_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               vde_o
);

    sideband_t  s0_in, s0_q, s0_d;
    stage1_t    s1_in, s1_q, s1_d;
    glyph_t     vram_glyph;
    logic [9:0] word_addr;
    logic       addr_ok;

    // Stage 0: issue the VRAM word read and capture the sideband.
    always_comb begin
        s0_in          = SB_RST;
        s0_in.draw_x   = drawX;
        s0_in.draw_y   = drawY;
        s0_in.hsync    = hsync_in;
        s0_in.vsync    = vsync_in;
        s0_in.vde      = vde_in;
        s0_in.char_sel = drawX[4:3];
        s0_in.row      = drawY[3:0];
        s0_in.px_bit   = drawX[2:0];
        word_addr      = cell_word_addr(drawY[9:4], drawX[9:5]);
        // Coordinates outside the visible area never reach the VRAM address bus.
        addr_ok        = vde_in && (drawX < 10'(H_ACTIVE)) && (drawY < 10'(V_ACTIVE));
    end

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            vram_en   <= 1'b0;
            vram_addr <= '0;
            s0_q      <= SB_RST;
        end else begin
            vram_en   <= vde_in;
            vram_addr <= addr_ok ? VRAM_AW'(word_addr) : '0;
            s0_q      <= s0_in;
        end
    end

    pipe_delay #(
        .WIDTH   ($bits(sideband_t)),
        .DEPTH   (VRAM_LAT),
        .RST_VAL (SB_RST)
    ) u_sb_vram (
        .clk     (pixel_clk),
        .reset_n (reset_n),
        .din     (s0_q),
        .dout    (s0_d)
    );

    // Stage 1: pick the byte with the delayed char_sel, issue the font read.
    always_comb begin
        vram_glyph   = glyph_t'(vram_rdata[{s0_d.char_sel, 3'b000} +: 8]);
        s1_in        = S1_RST;
        s1_in.glyph  = vram_glyph;
        s1_in.draw_x = s0_d.draw_x;
        s1_in.draw_y = s0_d.draw_y;
        s1_in.hsync  = s0_d.hsync;
        s1_in.vsync  = s0_d.vsync;
        s1_in.vde    = s0_d.vde;
        s1_in.px_bit = s0_d.px_bit;
    end

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            font_addr <= '0;
            s1_q      <= S1_RST;
        end else begin
            font_addr <= {vram_glyph.code, s0_d.row};
            s1_q      <= s1_in;
        end
    end

    pipe_delay #(
        .WIDTH   ($bits(stage1_t)),
        .DEPTH   (FONT_LAT),
        .RST_VAL (S1_RST)
    ) u_sb_font (
        .clk     (pixel_clk),
        .reset_n (reset_n),
        .din     (s1_q),
        .dout    (s1_d)
    );

    // Stage 2: font bit MSB-first, inverted by the attribute, forced off in blanking.
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            pix_on       <= 1'b0;
            glyph_code_o <= '0;
            invert_o     <= 1'b0;
            drawX_o      <= '0;
            drawY_o      <= '0;
            hsync_o      <= 1'b1;
            vsync_o      <= 1'b1;
            vde_o        <= 1'b0;
        end else begin
            pix_on       <= s1_d.vde & (font_data[3'd7 - s1_d.px_bit] ^ s1_d.glyph.invert);
            glyph_code_o <= s1_d.glyph.code;
            invert_o     <= s1_d.glyph.invert;
            drawX_o      <= s1_d.draw_x;
            drawY_o      <= s1_d.draw_y;
            hsync_o      <= s1_d.hsync;
            vsync_o      <= s1_d.vsync;
            vde_o        <= s1_d.vde;
        end
    end

endmodule
